// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the load/store unit.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Halfword lane comes from addr[1] only; addr[0] is ignored here.
  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    case (op)
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data = {24'd0, byte_s};
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data = {16'd0, half_s};
      OP_LW:   load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged = wdata;
    case (op)
      OP_SB: begin
        merged = rdata;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      OP_SH: begin
        merged = rdata;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-wide dmem; sub-word stores run read-modify-write.
// Optional LSU_ALIGN_CHECK_EN turns misaligned halfword/word accesses into error responses.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    state;
  logic [3:0]    op_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wword_p1;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merged;
  logic          misalign;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0]) ||
                    ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_mux u_lane_mux (
    .op        (op_p0),
    .addr_lo   (addr_p0[1:0]),
    .rdata     (mem_rdata),
    .wdata     (wword_p1),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_addr   = (state == ST_RD || state == ST_WR) ? {addr_p0[AW-1:2], 2'b00} : '0;
  assign mem_wdata  = (state == ST_WR) ? wword_p1 : '0;
  // Reset gates the strobe directly so an aborted write never reaches dmem.
  assign mem_we     = (state == ST_WR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_p0      <= '0;
      addr_p0    <= '0;
      wword_p1   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        // Accept: latch the request, pick the path, clear the previous response.
        ST_IDLE: begin
          if (req_valid) begin
            op_p0      <= req_op;
            addr_p0    <= req_addr;
            wword_p1   <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (!is_legal(req_op) || misalign) begin
              resp_err <= 1'b1;
              state    <= ST_RESP;
            end else if (req_op == OP_SW) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        // Read: loads finish here, sub-word stores fold their lane into the word.
        ST_RD: begin
          if (is_load(op_p0)) begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end else begin
            wword_p1 <= merged;
            state    <= ST_WR;
          end
        end
        ST_WR: state <= ST_RESP;
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
